pipe_if: RTL and testbench
==========================

PIPE_IF -- requirements
Module: pipe_if

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; port list follows in REQ-002..REQ-018.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 i_stall  input  1  ID load-use stall; hold PC and IF/ID register.
REQ-005 i_mux_pc  input  8  next-PC select from ID: 8'h00 sequential, 8'h01 branch (i_ext18), 8'h02 jump (i_II), 8'h04 register (i_rs_data), 8'h08 exception (i_exc_addr); any other value treated as 8'h00.
REQ-006 i_ext18  input  32  branch target computed in ID.
REQ-007 i_II  input  32  jump target computed in ID.
REQ-008 i_rs_data  input  32  forwarded rs value for jr/jalr.
REQ-009 i_exc_addr  input  32  CP0 exception/eret vector.
REQ-010 i_branch_predict_fail  input  1  misprediction detected in ID.
REQ-011 i_branch_fail_pc  input  32  correct PC after misprediction.
REQ-012 i_bp_update / i_bp_pc[31:0] / i_bp_taken  input  1/32/1  predictor training from resolved branch.
REQ-013 o_imem_addr  output  32  instruction memory address (current PC).
REQ-014 i_imem_rdata  input  32  instruction word, combinational read of o_imem_addr.
REQ-015 o_inst  output  32  registered instruction to ID.
REQ-016 o_pc4  output  32  registered PC+4 of o_inst.
REQ-017 o_valid  output  1  o_inst is a real fetched instruction (0 = bubble).
REQ-018 o_branch_predict  output  1  o_inst was fetched with predict-taken redirect applied.

Function
REQ-019 PC register SHALL drive o_imem_addr directly; PC[1:0] SHALL always be 2'b00 (low bits of every loaded target forced to zero).
REQ-020 Fetch latency SHALL be one cycle: instruction at PC appears on o_inst after the next rising edge, with o_pc4 = PC+4 (mod 2^32; 32'hFFFFFFFC wraps to 32'h00000000).
REQ-021 Next-PC priority (highest first): rst; i_branch_predict_fail -> i_branch_fail_pc; i_mux_pc==8'h08 -> i_exc_addr; i_stall -> hold; i_mux_pc 8'h01/02/04 -> selected target; local predict-taken -> predicted target; else PC+4.
REQ-022 On misprediction or exception redirect the IF/ID register SHALL be flushed: o_inst=32'h0, o_valid=0, o_branch_predict=0, o_pc4 unchanged.
REQ-023 On i_stall (no redirect) o_inst, o_pc4, o_valid, o_branch_predict SHALL hold their values.
REQ-024 On i_mux_pc 8'h01/02/04 the instruction currently fetched (delay slot) SHALL be latched normally, o_valid=1.
REQ-025 Redirect and stall asserted together: redirect wins, stall ignored for that cycle.

Reset
REQ-026 On rst: PC=32'h00400000, o_inst=32'h0, o_pc4=32'h0, o_valid=0, o_branch_predict=0, all predictor counters=2'b01.
REQ-027 rst asserted mid-stall or mid-redirect SHALL override both within the same edge.

Configuration
REQ-028 Macro IF_BRANCH_PREDICT_EN SHALL compile in a 16-entry table of 2-bit saturating counters indexed by PC[5:2].
REQ-029 With it: fetched opcode 6'h04/6'h05 and counter[1]==1 -> next PC = PC+4+(sign-extended imm<<2) unless overridden per REQ-021, o_branch_predict=1 with that instruction.
REQ-030 With it: i_bp_update increments (taken) or decrements (not taken) entry i_bp_pc[5:2], saturating at 2'b11/2'b00; same-cycle lookup of the updated entry uses the pre-update value.
REQ-031 Without it: no table, o_branch_predict constant 0, i_bp_* ignored, sequential fetch only.

Verification
REQ-032 Reset then 3 free cycles -> o_imem_addr 0x00400000, 0x00400004, 0x00400008, 0x0040000C; o_valid 0 then 1.
REQ-033 i_stall=1 for 2 cycles at PC 0x00400008 -> PC and o_inst/o_pc4 frozen 2 cycles, resume 0x0040000C.
REQ-034 i_mux_pc=8'h02, i_II=0x00400100 -> next PC 0x00400100, delay-slot inst latched with o_valid=1.
REQ-035 i_branch_predict_fail=1, i_branch_fail_pc=0x00400040 with i_stall=1 and i_mux_pc=8'h08 -> PC 0x00400040, o_valid=0, o_inst=0.
REQ-036 (IF_BRANCH_PREDICT_EN) two i_bp_update taken at 0x00400020, then fetch beq imm=16'h0004 at 0x00400020 -> next PC 0x00400034, o_branch_predict=1; without macro -> 0x00400024, o_branch_predict=0.
REQ-037 PC forced to 0xFFFFFFFC via i_rs_data -> o_pc4 0x00000000 next cycle, following fetch at 0x00000000.

Source files
------------

// File: rtl/pipe_if_if.sv
// Fetch-stage bus: ID-stage control, predictor training, instruction memory and IF/ID outputs.
// The ID side uses the master modport; the fetch stage uses the slave modport.
interface pipe_if_if;
  logic        i_stall;
  logic [7:0]  i_mux_pc;
  logic [31:0] i_ext18;
  logic [31:0] i_II;
  logic [31:0] i_rs_data;
  logic [31:0] i_exc_addr;
  logic        i_branch_predict_fail;
  logic [31:0] i_branch_fail_pc;
  logic        i_bp_update;
  logic [31:0] i_bp_pc;
  logic        i_bp_taken;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_inst;
  logic [31:0] o_pc4;
  logic        o_valid;
  logic        o_branch_predict;

  modport master (
    output i_stall, i_mux_pc, i_ext18, i_II, i_rs_data, i_exc_addr,
           i_branch_predict_fail, i_branch_fail_pc,
           i_bp_update, i_bp_pc, i_bp_taken, i_imem_rdata,
    input  o_imem_addr, o_inst, o_pc4, o_valid, o_branch_predict
  );

  modport slave (
    input  i_stall, i_mux_pc, i_ext18, i_II, i_rs_data, i_exc_addr,
           i_branch_predict_fail, i_branch_fail_pc,
           i_bp_update, i_bp_pc, i_bp_taken, i_imem_rdata,
    output o_imem_addr, o_inst, o_pc4, o_valid, o_branch_predict
  );
endinterface

// File: rtl/pipe_if.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Define IF_BRANCH_PREDICT_EN to add a 16-entry 2-bit counter branch predictor.
module pipe_if (
  input  logic     clk,
  input  logic     rst,
  pipe_if_if.slave bus
);

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [7:0]  MUX_BR   = 8'h01;
  localparam logic [7:0]  MUX_J    = 8'h02;
  localparam logic [7:0]  MUX_JR   = 8'h04;
  localparam logic [7:0]  MUX_EXC  = 8'h08;

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        bp_q, bp_d;

  logic [31:0] pc_plus4;
  logic        predict_taken;
  logic [31:0] pred_target;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef IF_BRANCH_PREDICT_EN
  logic [5:0]  opcode;
  logic [15:0] imm;
  logic [31:0] br_off;
  logic [15:0] ctr_msb;
  logic        bp_pc_unused;

  assign opcode = bus.i_imem_rdata[31:26];
  assign imm    = bus.i_imem_rdata[15:0];
  assign br_off = {{14{imm[15]}}, imm, 2'b00};
  assign bp_pc_unused = ^{bus.i_bp_pc[31:6], bus.i_bp_pc[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_ctr
      logic [1:0] cnt_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= 2'b01;
        end else if (bus.i_bp_update && (bus.i_bp_pc[5:2] == 4'(gi))) begin
          if (bus.i_bp_taken) begin
            if (cnt_q != 2'b11) cnt_q <= cnt_q + 2'b01;
          end else begin
            if (cnt_q != 2'b00) cnt_q <= cnt_q - 2'b01;
          end
        end
      end
      assign ctr_msb[gi] = cnt_q[1];
    end
  endgenerate

  // Lookup reads the registered counter, so a same-cycle update is not yet visible.
  assign predict_taken = ((opcode == 6'h04) || (opcode == 6'h05)) && ctr_msb[pc_q[5:2]];
  assign pred_target   = pc_plus4 + br_off;
`else
  logic bp_unused;
  assign bp_unused     = ^{bus.i_bp_update, bus.i_bp_pc, bus.i_bp_taken};
  assign predict_taken = 1'b0;
  assign pred_target   = 32'h0;
`endif

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    bp_d    = bp_q;

    if (bus.i_branch_predict_fail || (bus.i_mux_pc == MUX_EXC)) begin
      // Redirects flush IF/ID but leave pc4 alone; they also override a stall.
      pc_d    = bus.i_branch_predict_fail ? {bus.i_branch_fail_pc[31:2], 2'b00}
                                          : {bus.i_exc_addr[31:2], 2'b00};
      inst_d  = 32'h0;
      valid_d = 1'b0;
      bp_d    = 1'b0;
    end else if (!bus.i_stall) begin
      inst_d  = bus.i_imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      bp_d    = 1'b0;
      case (bus.i_mux_pc)
        MUX_BR:  pc_d = {bus.i_ext18[31:2], 2'b00};
        MUX_J:   pc_d = {bus.i_II[31:2], 2'b00};
        MUX_JR:  pc_d = {bus.i_rs_data[31:2], 2'b00};
        default: begin
          if (predict_taken) begin
            pc_d = {pred_target[31:2], 2'b00};
            bp_d = 1'b1;
          end else begin
            pc_d = pc_plus4;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      bp_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      bp_q    <= bp_d;
    end
  end

  assign bus.o_imem_addr      = pc_q;
  assign bus.o_inst           = inst_q;
  assign bus.o_pc4            = pc4_q;
  assign bus.o_valid          = valid_q;
  assign bus.o_branch_predict = bp_q;

endmodule

// File: tb/tb_pipe_if.sv
// Directed bench for pipe_if: reset, stall, ID redirects, flushes, prediction and PC wrap.
module tb_pipe_if;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pipe_if_if bus ();

  pipe_if dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: one beq at 0x00400020, otherwise address-tagged lw words.
  function automatic logic [31:0] inst_at(input logic [31:0] a);
    if (a == 32'h0040_0020) return 32'h1022_0004;
    return {6'h23, a[25:0]};
  endfunction

  assign bus.i_imem_rdata = inst_at(bus.o_imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t pc=%08h inst=%08h pc4=%08h valid=%0b bp=%0b", $time,
             bus.o_imem_addr, bus.o_inst, bus.o_pc4, bus.o_valid, bus.o_branch_predict);
  endtask

  task automatic idle_inputs();
    bus.i_stall               = 1'b0;
    bus.i_mux_pc              = 8'h00;
    bus.i_ext18               = 32'h0;
    bus.i_II                  = 32'h0;
    bus.i_rs_data             = 32'h0;
    bus.i_exc_addr            = 32'h0;
    bus.i_branch_predict_fail = 1'b0;
    bus.i_branch_fail_pc      = 32'h0;
    bus.i_bp_update           = 1'b0;
    bus.i_bp_pc               = 32'h0;
    bus.i_bp_taken            = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    step();
    step();
    chk("rst_pc",    bus.o_imem_addr, 32'h0040_0000);
    chk("rst_inst",  bus.o_inst, 32'h0);
    chk("rst_pc4",   bus.o_pc4, 32'h0);
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_bp",    32'(bus.o_branch_predict), 32'h0);

    // Free-running sequential fetch
    rst = 1'b0;
    step();
    chk("seq1_pc",    bus.o_imem_addr, 32'h0040_0004);
    chk("seq1_inst",  bus.o_inst, inst_at(32'h0040_0000));
    chk("seq1_pc4",   bus.o_pc4, 32'h0040_0004);
    chk("seq1_valid", 32'(bus.o_valid), 32'h1);
    step();
    chk("seq2_pc",    bus.o_imem_addr, 32'h0040_0008);
    chk("seq2_inst",  bus.o_inst, inst_at(32'h0040_0004));

    // Two-cycle stall at 0x00400008
    bus.i_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall_pc",   bus.o_imem_addr, 32'h0040_0008);
      chk("stall_inst", bus.o_inst, inst_at(32'h0040_0004));
      chk("stall_pc4",  bus.o_pc4, 32'h0040_0008);
    end
    bus.i_stall = 1'b0;
    step();
    chk("resume_pc",   bus.o_imem_addr, 32'h0040_000C);
    chk("resume_inst", bus.o_inst, inst_at(32'h0040_0008));
    chk("resume_pc4",  bus.o_pc4, 32'h0040_000C);

    // Jump with delay slot latched
    bus.i_mux_pc = 8'h02;
    bus.i_II     = 32'h0040_0100;
    step();
    chk("jump_pc",    bus.o_imem_addr, 32'h0040_0100);
    chk("jump_inst",  bus.o_inst, inst_at(32'h0040_000C));
    chk("jump_pc4",   bus.o_pc4, 32'h0040_0010);
    chk("jump_valid", 32'(bus.o_valid), 32'h1);

    // Branch target with low bits forced to zero
    bus.i_mux_pc = 8'h01;
    bus.i_ext18  = 32'h0040_0203;
    step();
    chk("br_pc",   bus.o_imem_addr, 32'h0040_0200);
    chk("br_inst", bus.o_inst, inst_at(32'h0040_0100));

    // Unlisted select value behaves as sequential
    bus.i_mux_pc = 8'h10;
    step();
    chk("badsel_pc",  bus.o_imem_addr, 32'h0040_0204);
    chk("badsel_pc4", bus.o_pc4, 32'h0040_0204);

    // Misprediction beats exception and stall; flush keeps pc4
    bus.i_mux_pc              = 8'h08;
    bus.i_exc_addr            = 32'h8000_0180;
    bus.i_stall               = 1'b1;
    bus.i_branch_predict_fail = 1'b1;
    bus.i_branch_fail_pc      = 32'h0040_0040;
    step();
    chk("mispred_pc",    bus.o_imem_addr, 32'h0040_0040);
    chk("mispred_inst",  bus.o_inst, 32'h0);
    chk("mispred_valid", 32'(bus.o_valid), 32'h0);
    chk("mispred_pc4",   bus.o_pc4, 32'h0040_0204);

    // Exception redirect beats stall
    bus.i_branch_predict_fail = 1'b0;
    step();
    chk("exc_pc",    bus.o_imem_addr, 32'h8000_0180);
    chk("exc_valid", 32'(bus.o_valid), 32'h0);
    chk("exc_pc4",   bus.o_pc4, 32'h0040_0204);

    // Train predictor during a stall, bubble must hold
    idle_inputs();
    bus.i_stall     = 1'b1;
    bus.i_bp_update = 1'b1;
    bus.i_bp_taken  = 1'b1;
    bus.i_bp_pc     = 32'h0040_0020;
    step();
    step();
    chk("train_pc",    bus.o_imem_addr, 32'h8000_0180);
    chk("train_valid", 32'(bus.o_valid), 32'h0);

    idle_inputs();
    bus.i_mux_pc = 8'h02;
    bus.i_II     = 32'h0040_0020;
    step();
    chk("tobeq_pc",    bus.o_imem_addr, 32'h0040_0020);
    chk("tobeq_inst",  bus.o_inst, inst_at(32'h8000_0180));
    chk("tobeq_valid", 32'(bus.o_valid), 32'h1);

    bus.i_mux_pc = 8'h00;
    step();
    chk("beq_inst", bus.o_inst, 32'h1022_0004);
    chk("beq_pc4",  bus.o_pc4, 32'h0040_0024);
`ifdef IF_BRANCH_PREDICT_EN
    chk("beq_next_pc", bus.o_imem_addr, 32'h0040_0034);
    chk("beq_bp",      32'(bus.o_branch_predict), 32'h1);
`else
    chk("beq_next_pc", bus.o_imem_addr, 32'h0040_0024);
    chk("beq_bp",      32'(bus.o_branch_predict), 32'h0);
`endif

    // Register jump to top of address space, then wrap
    bus.i_mux_pc  = 8'h04;
    bus.i_rs_data = 32'hFFFF_FFFE;
    step();
    chk("jr_pc", bus.o_imem_addr, 32'hFFFF_FFFC);
    chk("jr_bp", 32'(bus.o_branch_predict), 32'h0);
    bus.i_mux_pc = 8'h00;
    step();
    chk("wrap_pc",   bus.o_imem_addr, 32'h0000_0000);
    chk("wrap_pc4",  bus.o_pc4, 32'h0000_0000);
    chk("wrap_inst", bus.o_inst, inst_at(32'hFFFF_FFFC));
    step();
    chk("post_wrap_pc",   bus.o_imem_addr, 32'h0000_0004);
    chk("post_wrap_pc4",  bus.o_pc4, 32'h0000_0004);
    chk("post_wrap_inst", bus.o_inst, inst_at(32'h0000_0000));

    // Reset overrides simultaneous stall and redirect
    bus.i_stall               = 1'b1;
    bus.i_branch_predict_fail = 1'b1;
    bus.i_branch_fail_pc      = 32'h0040_0040;
    bus.i_mux_pc              = 8'h08;
    rst                       = 1'b1;
    step();
    chk("rst2_pc",    bus.o_imem_addr, 32'h0040_0000);
    chk("rst2_pc4",   bus.o_pc4, 32'h0);
    chk("rst2_valid", 32'(bus.o_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
